// File: rtl/conv_acc_argmax.sv
// rtl/conv_acc_argmax.sv - sequential argmax over a captured score vector, optional runner-up margin
// Optional feature macro: CONV_ACC_ARGMAX_MARGIN_EN (builds the runner-up tracker and o_margin)
module conv_acc_argmax #(
    parameter int NUM_CLASS = 10,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = $clog2(NUM_CLASS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_pre_valid,
    output logic                     o_pre_ready,
    input  logic signed [DATA_W-1:0] i_scores [NUM_CLASS-1:0],
    output logic                     o_post_valid,
    input  logic                     i_post_ready,
    output logic [IDX_W-1:0]         o_class,
    output logic signed [DATA_W-1:0] o_max,
    output logic [DATA_W-1:0]        o_margin
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASS - 1);

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [DATA_W-1:0]   best_q, best_d;
    logic signed [DATA_W-1:0]   buf_q [NUM_CLASS-1:0];
    logic signed [DATA_W-1:0]   buf_d [NUM_CLASS-1:0];
    logic                       pre_ready_q, pre_ready_d;
    logic                       post_valid_q, post_valid_d;
    logic [IDX_W-1:0]           class_q, class_d;
    logic signed [DATA_W-1:0]   max_q, max_d;
    logic signed [DATA_W-1:0]   scan_s;
`ifdef CONV_ACC_ARGMAX_MARGIN_EN
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    logic signed [DATA_W-1:0]   second_q, second_d;
    logic [DATA_W-1:0]          margin_q, margin_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        best_d       = best_q;
        buf_d        = buf_q;
        pre_ready_d  = pre_ready_q;
        post_valid_d = post_valid_q;
        class_d      = class_q;
        max_d        = max_q;
        scan_s       = buf_q[cnt_q];
`ifdef CONV_ACC_ARGMAX_MARGIN_EN
        second_d     = second_q;
        margin_d     = margin_q;
`endif
        case (state_q)
            IDLE: begin
                pre_ready_d = 1'b1;
                if (i_pre_valid && pre_ready_q) begin
                    for (int k = 0; k < NUM_CLASS; k++) begin
                        buf_d[k] = i_scores[k];
                    end
                    best_d      = i_scores[0];
                    idx_d       = '0;
                    cnt_d       = IDX_W'(1);
`ifdef CONV_ACC_ARGMAX_MARGIN_EN
                    second_d    = MOST_NEG;
`endif
                    pre_ready_d = 1'b0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                // strict '>' keeps the lower index on ties; a tie with best lands in second
                if (scan_s > best_q) begin
`ifdef CONV_ACC_ARGMAX_MARGIN_EN
                    second_d = best_q;
`endif
                    best_d = scan_s;
                    idx_d  = cnt_q;
                end
`ifdef CONV_ACC_ARGMAX_MARGIN_EN
                else if (scan_s > second_q) begin
                    second_d = scan_s;
                end
`endif
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST) begin
                    state_d      = DONE;
                    post_valid_d = 1'b1;
                    class_d      = idx_d;
                    max_d        = best_d;
`ifdef CONV_ACC_ARGMAX_MARGIN_EN
                    margin_d     = best_d - second_d;
`endif
                end
            end
            DONE: begin
                if (i_post_ready) begin
                    post_valid_d = 1'b0;
                    pre_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            best_q       <= '0;
            buf_q        <= '{default: '0};
            pre_ready_q  <= 1'b0;
            post_valid_q <= 1'b0;
            class_q      <= '0;
            max_q        <= '0;
`ifdef CONV_ACC_ARGMAX_MARGIN_EN
            second_q     <= '0;
            margin_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            best_q       <= best_d;
            buf_q        <= buf_d;
            pre_ready_q  <= pre_ready_d;
            post_valid_q <= post_valid_d;
            class_q      <= class_d;
            max_q        <= max_d;
`ifdef CONV_ACC_ARGMAX_MARGIN_EN
            second_q     <= second_d;
            margin_q     <= margin_d;
`endif
        end
    end

    assign o_pre_ready  = pre_ready_q;
    assign o_post_valid = post_valid_q;
    assign o_class      = class_q;
    assign o_max        = max_q;
`ifdef CONV_ACC_ARGMAX_MARGIN_EN
    assign o_margin     = margin_q;
`else
    assign o_margin     = '0;
`endif

endmodule

// File: tb/tb_conv_acc_argmax.sv
// tb/tb_conv_acc_argmax.sv - randomized and directed bench for conv_acc_argmax
module tb_conv_acc_argmax;

`ifdef CONV_ACC_ARGMAX_MARGIN_EN
    localparam bit MARGIN_ON = 1'b1;
`else
    localparam bit MARGIN_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pre_valid = 1'b0;
    logic               pre_ready;
    logic signed [31:0] scores [9:0];
    logic               post_valid;
    logic               post_ready = 1'b0;
    logic [3:0]         cls;
    logic signed [31:0] mx;
    logic [31:0]        margin;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_class, exp_max, exp_margin;

    conv_acc_argmax dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pre_valid  (pre_valid),
        .o_pre_ready  (pre_ready),
        .i_scores     (scores),
        .o_post_valid (post_valid),
        .i_post_ready (post_ready),
        .o_class      (cls),
        .o_max        (mx),
        .o_margin     (margin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: winner is the first occurrence of the maximum; runner-up is the
    // largest of all the other entries (so a duplicated maximum gives margin 0).
    task automatic model();
        int win;
        logic signed [31:0] best, second;
        win  = 0;
        best = scores[0];
        for (int k = 1; k < 10; k++)
            if (scores[k] > best) begin best = scores[k]; win = k; end
        second = 32'sh8000_0000;
        for (int k = 0; k < 10; k++)
            if (k != win && scores[k] > second) second = scores[k];
        exp_class  = 32'(win);
        exp_max    = best;
        exp_margin = MARGIN_ON ? 32'(best - second) : 32'd0;
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!post_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_class"}, 32'(cls), exp_class);
        check({tag, "_max"}, mx, exp_max);
        check({tag, "_margin"}, margin, exp_margin);
    endtask

    // Called at a negedge with the stage idle; scores already loaded.
    task automatic run_frame(input string tag, input bit early_ready);
        check({tag, "_pre_ready"}, 32'(pre_ready), 32'd1);
        pre_valid  = 1'b1;
        post_ready = early_ready;
        @(negedge clk);
        pre_valid = 1'b0;
        check({tag, "_scan_busy"}, 32'(pre_ready), 32'd0);
        wait_result(tag);
        post_ready = 1'b1;
        @(negedge clk);
        post_ready = 1'b0;
        check({tag, "_post_drop"}, 32'(post_valid), 32'd0);
        check({tag, "_re_ready"}, 32'(pre_ready), 32'd1);
    endtask

    initial begin
        int bad;
        bit seen;
        for (int k = 0; k < 10; k++) scores[k] = '0;

        repeat (3) @(negedge clk);
        check("rst_pre_ready", 32'(pre_ready), 32'd0);
        check("rst_post_valid", 32'(post_valid), 32'd0);
        check("rst_class", 32'(cls), 32'd0);
        check("rst_max", mx, 32'd0);
        check("rst_margin", margin, 32'd0);
        rst_n = 1'b1;
        #1 check("rst_rel_pre_ready", 32'(pre_ready), 32'd0);
        @(negedge clk);
        check("first_edge_ready", 32'(pre_ready), 32'd1);

        // ramp 100*k
        for (int k = 0; k < 10; k++) scores[k] = 32'(100 * k);
        exp_class = 9; exp_max = 900; exp_margin = MARGIN_ON ? 32'd100 : 32'd0;
        run_frame("ramp", 1'b0);

        // all equal
        for (int k = 0; k < 10; k++) scores[k] = 32'sd5;
        exp_class = 0; exp_max = 5; exp_margin = 0;
        run_frame("tie", 1'b0);

        // negative scores, signed compare
        for (int k = 0; k < 10; k++) scores[k] = -32'sd1000;
        scores[3] = -32'sd1;
        exp_class = 3; exp_max = 32'hFFFF_FFFF; exp_margin = MARGIN_ON ? 32'd999 : 32'd0;
        run_frame("neg", 1'b1);

        // hold result under back-pressure while a new vector waits
        for (int k = 0; k < 10; k++) scores[k] = 32'(100 * k);
        exp_class = 9; exp_max = 900; exp_margin = MARGIN_ON ? 32'd100 : 32'd0;
        pre_valid = 1'b1;
        @(negedge clk);
        pre_valid = 1'b0;
        wait_result("hold_first");
        for (int k = 0; k < 10; k++) scores[k] = 32'($urandom_range(0, 2000)) - 32'sd1000;
        pre_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (post_valid !== 1'b1 || pre_ready !== 1'b0 || 32'(cls) !== 32'd9 ||
                mx !== 32'sd900 || margin !== (MARGIN_ON ? 32'd100 : 32'd0)) bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        model();
        post_ready = 1'b1;
        @(negedge clk);
        post_ready = 1'b0;
        check("hold_release_drop", 32'(post_valid), 32'd0);
        check("hold_release_ready", 32'(pre_ready), 32'd1);
        @(negedge clk);
        pre_valid = 1'b0;
        wait_result("hold_next");
        post_ready = 1'b1;
        @(negedge clk);
        post_ready = 1'b0;

        // reset during the fourth scan cycle
        for (int k = 0; k < 10; k++) scores[k] = 32'(50 * k);
        pre_valid = 1'b1;
        @(negedge clk);
        pre_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pre_ready", 32'(pre_ready), 32'd0);
        check("mid_rst_post_valid", 32'(post_valid), 32'd0);
        check("mid_rst_class", 32'(cls), 32'd0);
        check("mid_rst_max", mx, 32'd0);
        check("mid_rst_margin", margin, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (post_valid) seen = 1'b1;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);
        for (int k = 0; k < 10; k++) scores[k] = 32'(9 - k);
        exp_class = 0; exp_max = 9; exp_margin = MARGIN_ON ? 32'd1 : 32'd0;
        run_frame("post_rst", 1'b0);

        // randomized frames against the reference
        for (int f = 0; f < 40; f++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int k = 0; k < 10; k++) begin
                if (mode == 0)      scores[k] = $urandom;
                else if (mode == 1) scores[k] = 32'($urandom_range(0, 3));
                else                scores[k] = -32'($urandom_range(0, 50));
            end
            model();
            run_frame("rand", bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_acc_argmax.md
# conv_acc_argmax

Classification output stage downstream of `top_conv_acc`. It accepts the ten 32-bit FC scores `o_res[9:0]` on a valid/ready handshake and captures them. It then scans the scores sequentially, one compare per cycle, and presents the winning class index and its score on a valid/ready output port. The design exposes the score margin to the runner-up when that option is compiled in.

## Interface
Parameters:
- `NUM_CLASS`, 10, number of scores per frame (≥2)
- `DATA_W`, 32, score width, two's-complement signed
- `IDX_W`, `$clog2(NUM_CLASS)` (4), class index width

Ports:
- `i_clk`  in  1  single clock, rising edge
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_pre_valid`  in  1  score vector valid (driven from `top_conv_acc.o_post_valid`)
- `o_pre_ready`  out  1  stage can accept a vector
- `i_scores[NUM_CLASS-1:0]`  in  DATA_W each  FC scores, signed
- `o_post_valid`  out  1  result valid
- `i_post_ready`  in  1  consumer accepts result
- `o_class`  out  IDX_W  index of maximum score
- `o_max`  out  DATA_W  maximum score, signed
- `o_margin`  out  DATA_W  unsigned difference, max minus second-highest

## Operation
- FSM states: IDLE, SCAN, DONE. Reset enters IDLE.
- IDLE:
  - `o_pre_ready`=1.
  - On `i_pre_valid && o_pre_ready`, all scores are copied into an internal register array.
  - `best` is set to score[0], `idx` to 0, `cnt` to 1, and `second` to the most-negative value (`{1'b1,{DATA_W-1{1'b0}}}`).
  - The FSM then moves to SCAN.
- SCAN: each cycle compares `s = buf[cnt]` using a signed comparison.
  - If `s > best`: `second` gets `best`, then `best` gets `s` and `idx` gets `cnt`.
  - Else if `s > second`: `second` gets `s`.
  - Ties keep the lower index. A tie with `best` updates `second` only, so the margin is 0.
  - `cnt` increments. The compare at `cnt == NUM_CLASS-1` is the last, and the FSM moves to DONE.
- DONE:
  - `o_post_valid`=1, with `o_class`=`idx`, `o_max`=`best` and `o_margin`=`best-second` (unsigned DATA_W wrap-free, since the result fits in DATA_W bits unsigned).
  - Outputs are registered and held stable until `i_post_ready`. On the handshake the FSM returns to IDLE.
- `o_pre_ready`=0 in SCAN and DONE. `i_pre_valid` and `i_scores` are ignored there, so no overwrite of the captured vector is possible.
- Input scores are sampled only on the accept edge. Later changes on `i_scores` have no effect.

## Timing
- Reset values: `o_pre_ready`=0, `o_post_valid`=0, `o_class`=0, `o_max`=0, `o_margin`=0; `cnt`, `idx`, `best`, `second` and the buffer are all 0.
- `o_pre_ready` is registered. It rises on the first `i_clk` edge after `i_rst_n` deasserts.
- Let the accept edge be E0:
  - The SCAN compares occur on edges E1..E(NUM_CLASS-1).
  - `o_post_valid` rises after edge E(NUM_CLASS-1), i.e. 9 cycles after acceptance for NUM_CLASS=10.
- Output handshake on edge H:
  - `o_post_valid` falls and `o_pre_ready` rises after H.
  - The earliest next accept is H+1.
  - Minimum frame period is NUM_CLASS+1 = 11 cycles.
- Holding `i_post_ready`=1 in advance does not shorten latency. `o_post_valid` is held at least one cycle.
- Mid-operation reset (any state): all outputs immediately take their reset values and the captured frame is discarded. No result is ever produced for that frame.
- Simultaneous `i_pre_valid` and `i_post_ready` in DONE: only the output handshake completes. The input is accepted in IDLE afterwards.

## Configuration
- `CONV_ACC_ARGMAX_MARGIN_EN` defined:
  - The `second` register and its compare logic are built.
  - `o_margin` = `best − second`, valid with `o_post_valid`.
- Not defined:
  - `second` and its compare logic are removed.
  - `o_margin` is tied to 0.
  - Class, max and timing are unchanged.

## Test plan
- score[k]=100·k, k=0..9 → `o_class`=9, `o_max`=900, `o_margin`=100; `o_post_valid` rises exactly 9 cycles after the accept edge.
- All scores = 5 → `o_class`=0, `o_max`=5, `o_margin`=0 (tie rule).
- All scores = −1000 except score[3]=−1 → `o_class`=3, `o_max`=32'hFFFF_FFFF, `o_margin`=999 (signed compare).
- Results held with `i_post_ready`=0 for 20 cycles while `i_pre_valid`=1 with new data → outputs stable and `o_pre_ready`=0 throughout. After release, the old result is handshaked, `o_pre_ready`=1 the next cycle, and the new frame produces its own result.
- Assert `i_rst_n`=0 on the 4th SCAN cycle → all outputs 0 immediately and no `o_post_valid`. The next frame (score[k]=9−k) yields `o_class`=0, `o_max`=9, `o_margin`=1.
- Build without `CONV_ACC_ARGMAX_MARGIN_EN`, rerun scenario 1 → `o_class`=9, `o_max`=900, `o_margin`=0.
